// File: rtl/fifo36_pkg.sv
// fifo36_pkg: shared fifo36 stream field positions and arbiter state encoding.
// No ports; imported by the fifo36_arb_n design files.
package fifo36_pkg;
    localparam int FIFO36_SOF    = 32;
    localparam int FIFO36_EOF    = 33;
    localparam int FIFO36_OCC_HI = 35;
    localparam int FIFO36_OCC_LO = 34;
    // Channel indices fit in 3 bits because NUM_CH is at most 8.
    localparam int IDX_W = 3;
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;
endpackage

// File: rtl/fifo36_arb_n_if.sv
// fifo36_arb_n_if: N-channel fifo36 input streams plus one fifo36 output stream.
// data_i/src_rdy_i/dst_rdy_o: per-channel inputs and readies (channel k at data_i[36k+35:36k]).
// data_o/src_rdy_o/dst_rdy_i: merged output line, valid and downstream ready.
// slave: arbiter side; master: stream source/sink side.
interface fifo36_arb_n_if #(
    parameter int NUM_CH = 4
) ();
    logic [36*NUM_CH-1:0] data_i;
    logic [NUM_CH-1:0]    src_rdy_i;
    logic [NUM_CH-1:0]    dst_rdy_o;
    logic [35:0]          data_o;
    logic                 src_rdy_o;
    logic                 dst_rdy_i;
    modport slave (
        input  data_i, src_rdy_i, dst_rdy_i,
        output dst_rdy_o, data_o, src_rdy_o
    );
    modport master (
        output data_i, src_rdy_i, dst_rdy_i,
        input  dst_rdy_o, data_o, src_rdy_o
    );
endinterface

// File: rtl/fifo36_arb_n_rr_pick.sv
// rr_pick_n: combinational round-robin priority encoder over NUM_CH requests.
// req: request mask; last: previously granted index (search starts at last+1).
// found: any request set; idx: first requester at or after last+1, wrapping.
module rr_pick_n
    import fifo36_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);
    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] l, input int i);
        int t;
        t = int'(l) + i;
        return IDX_W'(t >= NUM_CH ? t - NUM_CH : t);
    endfunction

    assign found = |req;

    // Walk from the farthest position back to last+1 so the nearest requester wins.
    always_comb begin
        idx = '0;
        for (int i = NUM_CH; i >= 1; i--)
            for (int j = 0; j < NUM_CH; j++)
                if (req[j] && nxt(last, i) == IDX_W'(j))
                    idx = IDX_W'(j);
    end
endmodule

// File: rtl/fifo36_arb_n.sv
// fifo36_arb_n: packet-atomic N-input fifo36 arbiter with per-channel enable and priority class.
// clk/reset: stream clock, async active-high reset; clear: sync clear of FSM and counter.
// set_stb/set_addr/set_data: setting bus, control word at BASE = {hi_mask[15:8], en_mask[7:0]}.
// s: stream interface (slave); status: {pkt_count, 12'b0, busy, grant}.
module fifo36_arb_n
    import fifo36_pkg::*;
#(
    parameter int         NUM_CH = 4,
    parameter logic [7:0] BASE   = 8'd0,
    parameter int         CNT_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               set_stb,
    input  logic [7:0]         set_addr,
    input  logic [31:0]        set_data,
    fifo36_arb_n_if.slave      s,
    output logic [31:0]        status
);
    logic [7:0]        en_mask, hi_mask;
    logic [NUM_CH-1:0] elig, hi_elig, dst_sel;
    logic              hi_found, all_found, busy, sel_rdy, eof_xfer;
    logic [IDX_W-1:0]  hi_idx, all_idx;
    logic [35:0]       sel_data;
    state_t            state, state_n;
    logic [IDX_W-1:0]  grant, grant_n, last, last_n;
    logic [CNT_W-1:0]  pkt_count, pkt_count_n;
    logic              unused_ok;

    // Masks hold all 8 bits; only the low NUM_CH bits ever reach the arbiter.
    assign unused_ok = ^{set_data[31:16], en_mask, hi_mask};

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            en_mask <= '1;
            hi_mask <= '0;
        end else if (set_stb && set_addr == BASE) begin
            en_mask <= set_data[7:0];
            hi_mask <= set_data[15:8];
        end

    assign elig    = s.src_rdy_i & en_mask[NUM_CH-1:0];
    assign hi_elig = elig & hi_mask[NUM_CH-1:0];

    rr_pick_n #(.NUM_CH(NUM_CH)) u_hi (
        .req   (hi_elig),
        .last  (last),
        .found (hi_found),
        .idx   (hi_idx)
    );

    rr_pick_n #(.NUM_CH(NUM_CH)) u_all (
        .req   (elig),
        .last  (last),
        .found (all_found),
        .idx   (all_idx)
    );

    assign busy = (state == DATA);

    // Output mux follows the registered grant, so data_o is data_i[0] when idle after reset.
    always_comb begin
        sel_data = s.data_i[35:0];
        sel_rdy  = s.src_rdy_i[0];
        dst_sel  = '0;
        for (int j = 0; j < NUM_CH; j++)
            if (grant == IDX_W'(j)) begin
                sel_data   = s.data_i[36*j +: 36];
                sel_rdy    = s.src_rdy_i[j];
                dst_sel[j] = busy && s.dst_rdy_i;
            end
    end

    assign s.data_o    = sel_data;
    assign s.src_rdy_o = busy && sel_rdy;
    assign s.dst_rdy_o = dst_sel;
    assign eof_xfer    = busy && sel_rdy && s.dst_rdy_i && sel_data[FIFO36_EOF];

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= IDX_W'(NUM_CH - 1);
            pkt_count <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            last      <= last_n;
            pkt_count <= pkt_count_n;
        end

    // High class wins whenever any of its members is eligible; mask changes only matter here in IDLE.
    always_comb begin
        state_n     = state;
        grant_n     = grant;
        last_n      = last;
        pkt_count_n = pkt_count;
        if (clear) begin
            state_n     = IDLE;
            grant_n     = '0;
            last_n      = IDX_W'(NUM_CH - 1);
            pkt_count_n = '0;
        end else if (state == IDLE) begin
            state_n = all_found ? DATA : IDLE;
            grant_n = !all_found ? grant : hi_found ? hi_idx : all_idx;
        end else if (eof_xfer) begin
            state_n     = IDLE;
            last_n      = grant;
            pkt_count_n = pkt_count + 1'b1;
        end
    end

    assign status = {16'(pkt_count), 12'h000, busy, grant};
endmodule

// File: tb/tb_fifo36_arb_n.sv
// tb_fifo36_arb_n: self-checking bench for fifo36_arb_n with NUM_CH=4.
module tb_fifo36_arb_n;
    localparam int NUM_CH = 4;

    typedef struct {
        logic [7:0] en;
        logic [7:0] hi;
        logic [3:0] req;
        logic       busy;
        logic [2:0] grant;
    } tv_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'd0;
    logic [31:0] set_data = 32'd0;
    logic [31:0] status;

    fifo36_arb_n_if #(.NUM_CH(NUM_CH)) s ();

    fifo36_arb_n #(.NUM_CH(NUM_CH), .BASE(8'd0), .CNT_W(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .s        (s),
        .status   (status)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [35:0] chq [NUM_CH][$];
    logic [35:0] expq [$];
    bit          bp, stab_chk, gap_chk, seen_any, prev_hold, trig_en, wr_pend;
    int          gap;
    logic [35:0] prev_data, trig;
    logic [31:0] wr_data;
    tv_t         tv [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [35:0] mk(input int ch, input int pkt, input int idx, input int n);
        logic e, f;
        e = (idx == n - 1);
        f = (idx == 0);
        return {2'b11, e, f, 8'(ch), 8'(pkt), 16'(idx)};
    endfunction

    task automatic load(input int ch, input int pkt0, input int npkt, input int n);
        for (int p = pkt0; p < pkt0 + npkt; p++)
            for (int i = 0; i < n; i++) chq[ch].push_back(mk(ch, p, i, n));
    endtask

    task automatic expect_pkt(input int ch, input int pkt, input int n);
        for (int i = 0; i < n; i++) expq.push_back(mk(ch, pkt, i, n));
    endtask

    task automatic drive();
        for (int k = 0; k < NUM_CH; k++) begin
            s.src_rdy_i[k] = chq[k].size() > 0;
            s.data_i[36*k +: 36] = chq[k].size() > 0 ? chq[k][0] : 36'h0;
        end
        s.dst_rdy_i = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        set_stb = wr_pend;
        set_addr = 8'd0;
        set_data = wr_data;
        wr_pend = 1'b0;
    endtask

    task automatic observe();
        logic [NUM_CH-1:0] e;
        if (s.src_rdy_o) begin
            if (gap_chk && seen_any && gap > 0) chk("gap", 64'(gap), 64'd1);
            seen_any = 1'b1;
            gap = 0;
            if (s.dst_rdy_i) begin
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_out: got %0h required no output", s.data_o);
                end else chk("line", 64'(s.data_o), 64'(expq.pop_front()));
                if (trig_en && s.data_o == trig) begin
                    wr_pend = 1'b1;
                    trig_en = 1'b0;
                end
            end
        end else gap++;
        if (stab_chk) begin
            if (prev_hold) begin
                chk("hold_data", 64'(s.data_o), 64'(prev_data));
                chk("hold_valid", 64'(s.src_rdy_o), 64'd1);
            end
            e = status[3] ? (NUM_CH'(s.dst_rdy_i) << status[2:0]) : '0;
            chk("dst_rdy_o", 64'(s.dst_rdy_o), 64'(e));
        end
        prev_hold = s.src_rdy_o && !s.dst_rdy_i;
        prev_data = s.data_o;
    endtask

    task automatic cycle();
        logic [NUM_CH-1:0] take;
        @(negedge clk);
        observe();
        take = s.dst_rdy_o & s.src_rdy_i;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++)
            if (take[k]) void'(chq[k].pop_front());
        drive();
    endtask

    task automatic run(input int budget);
        int n = 0;
        while (expq.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("timeout_left", 64'(expq.size()), 64'd0);
    endtask

    task automatic wr(input logic [31:0] d);
        set_stb = 1'b1;
        set_addr = 8'd0;
        set_data = d;
        @(posedge clk);
        #1;
        set_stb = 1'b0;
    endtask

    task automatic begin_test();
        for (int k = 0; k < NUM_CH; k++) chq[k].delete();
        expq.delete();
        seen_any = 1'b0;
        gap = 0;
        prev_hold = 1'b0;
        trig_en = 1'b0;
        wr_pend = 1'b0;
        clear = 1'b1;
        drive();
        @(posedge clk);
        #1;
        clear = 1'b0;
        drive();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0] = '{8'hFF, 8'h00, 4'b0001, 1'b1, 3'd0};
        tv[1] = '{8'hFF, 8'h00, 4'b0110, 1'b1, 3'd1};
        tv[2] = '{8'hFF, 8'h00, 4'b1000, 1'b1, 3'd3};
        tv[3] = '{8'hFF, 8'h04, 4'b1111, 1'b1, 3'd2};
        tv[4] = '{8'hFF, 8'h0C, 4'b1010, 1'b1, 3'd3};
        tv[5] = '{8'h0D, 8'h00, 4'b0010, 1'b0, 3'd0};
        tv[6] = '{8'h0E, 8'h01, 4'b0011, 1'b1, 3'd1};
        tv[7] = '{8'hFF, 8'h03, 4'b0110, 1'b1, 3'd1};
        tv[8] = '{8'h00, 8'h00, 4'b1111, 1'b0, 3'd0};
        tv[9] = '{8'hF5, 8'hF0, 4'b1110, 1'b1, 3'd2};
        bp = 1'b0;
        stab_chk = 1'b0;
        gap_chk = 1'b1;
        wr_data = 32'd0;
        trig = '0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_src_rdy_o", 64'(s.src_rdy_o), 64'd0);
        chk("rst_dst_rdy_o", 64'(s.dst_rdy_o), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single IDLE decisions straight after clear (search starts at channel 0).
        for (int t = 0; t < 10; t++) begin
            s.src_rdy_i = '0;
            s.dst_rdy_i = 1'b0;
            clear = 1'b1;
            set_stb = 1'b1;
            set_data = {16'h0, tv[t].hi, tv[t].en};
            @(posedge clk);
            #1;
            clear = 1'b0;
            set_stb = 1'b0;
            for (int k = 0; k < NUM_CH; k++) s.data_i[36*k +: 36] = mk(k, 0, 0, 2);
            s.src_rdy_i = tv[t].req;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_busy_grant", t), 64'(status[3:0]), 64'({tv[t].busy, tv[t].grant}));
            chk($sformatf("tbl%0d_src_rdy_o", t), 64'(s.src_rdy_o), 64'(tv[t].busy));
            chk($sformatf("tbl%0d_data_o", t), 64'(s.data_o), 64'(mk(int'(tv[t].grant), 0, 0, 2)));
            chk($sformatf("tbl%0d_dst_rdy_o", t), 64'(s.dst_rdy_o), 64'd0);
            @(posedge clk);
            #1;
        end

        // Round robin over four channels, three 4-line packets each.
        begin_test();
        wr(32'h0000_00FF);
        for (int k = 0; k < NUM_CH; k++) load(k, 0, 3, 4);
        for (int p = 0; p < 3; p++)
            for (int k = 0; k < NUM_CH; k++) expect_pkt(k, p, 4);
        drive();
        run(300);
        cycle();
        chk("rr_pkt_count", 64'(status[31:16]), 64'd12);
        chk("rr_busy", 64'(status[3]), 64'd0);

        // High class on channel 2, then cleared mid-packet: rotation resumes at 3.
        begin_test();
        wr(32'h0000_04FF);
        load(2, 0, 5, 4);
        load(0, 0, 1, 4);
        load(1, 0, 1, 4);
        load(3, 0, 1, 4);
        expect_pkt(2, 0, 4);
        expect_pkt(2, 1, 4);
        expect_pkt(2, 2, 4);
        expect_pkt(3, 0, 4);
        expect_pkt(0, 0, 4);
        expect_pkt(1, 0, 4);
        expect_pkt(2, 3, 4);
        expect_pkt(2, 4, 4);
        trig = mk(2, 2, 1, 4);
        wr_data = 32'h0000_00FF;
        trig_en = 1'b1;
        drive();
        run(300);

        // Disable channel 1 while its packet is in flight.
        begin_test();
        wr(32'h0000_00FF);
        load(0, 0, 1, 4);
        load(1, 0, 2, 4);
        load(2, 0, 1, 4);
        load(3, 0, 1, 4);
        expect_pkt(0, 0, 4);
        expect_pkt(1, 0, 4);
        expect_pkt(2, 0, 4);
        expect_pkt(3, 0, 4);
        trig = mk(1, 0, 1, 4);
        wr_data = 32'h0000_000D;
        trig_en = 1'b1;
        drive();
        run(300);
        repeat (20) cycle();
        chk("en_ch1_left", 64'(chq[1].size()), 64'd4);
        wr(32'h0000_00FF);

        // 100-line packet under random 50% backpressure.
        begin_test();
        load(0, 0, 1, 100);
        expect_pkt(0, 0, 100);
        bp = 1'b1;
        stab_chk = 1'b1;
        drive();
        run(1000);
        bp = 1'b0;
        stab_chk = 1'b0;
        prev_hold = 1'b0;

        // Single-line packets alternate with one bubble each.
        begin_test();
        load(0, 0, 3, 1);
        load(1, 0, 3, 1);
        for (int p = 0; p < 3; p++) begin
            expect_pkt(0, p, 1);
            expect_pkt(1, p, 1);
        end
        drive();
        run(100);
        cycle();
        chk("single_pkt_count", 64'(status[31:16]), 64'd6);

        // Reset on line 5 of a 10-line packet.
        for (int k = 0; k < NUM_CH; k++) chq[k].delete();
        expq.delete();
        seen_any = 1'b0;
        load(0, 9, 1, 10);
        expect_pkt(0, 9, 10);
        drive();
        for (int n = 0; n < 60 && expq.size() > 6; n++) cycle();
        chk("pre_reset_lines_left", 64'(expq.size()), 64'd6);
        @(negedge clk);
        chk("pre_reset_count", 64'(status[31:16]), 64'd6);
        reset = 1'b1;
        #1;
        chk("async_rst_src_rdy_o", 64'(s.src_rdy_o), 64'd0);
        chk("async_rst_dst_rdy_o", 64'(s.dst_rdy_o), 64'd0);
        chk("async_rst_status", 64'(status), 64'd0);
        chk("async_rst_data_o", 64'(s.data_o), 64'(mk(0, 9, 4, 10)));
        for (int k = 0; k < NUM_CH; k++) chq[k].delete();
        expq.delete();
        drive();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_status", 64'(status), 64'd0);
        seen_any = 1'b0;
        load(0, 0, 1, 3);
        load(1, 0, 1, 3);
        load(2, 0, 1, 3);
        expect_pkt(0, 0, 3);
        expect_pkt(1, 0, 3);
        expect_pkt(2, 0, 3);
        drive();
        run(100);
        cycle();
        chk("post_rst_pkt_count", 64'(status[31:16]), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/fifo36_arb_n.md
# fifo36_arb_n

Parametrised N-input, packet-atomic arbiter for the 36-bit fifo36 stream format. It generalises the two-input fixed-mode combiner tree that feeds the UDP TX protocol engine into one block with runtime-programmable per-channel enable and priority class. Arbitration is round-robin within a class, and a packet counter is exposed as status. It sits in the router between the err/cpu/dsp sources and the protocol engine, and replaces the cascade of two-input muxes.

## Interface
Parameters:
- NUM_CH, 4: number of input channels; legal range 2..8.
- BASE, 0: setting-register address of the control word.
- CNT_W, 16: width of the packet counter.

Ports:
- clk  in  1  stream clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous clear; same effect as reset, applied on the clock edge.
- set_stb  in  1  setting-register strobe.
- set_addr  in  8  setting-register address.
- set_data  in  32  setting-register data.
- data_i  in  36*NUM_CH  channel k occupies bits [36k+35:36k]. Bit 32 = SOF, bit 33 = EOF, bits [35:34] = occupancy, passed through unchanged.
- src_rdy_i  in  NUM_CH  per-channel valid.
- dst_rdy_o  out  NUM_CH  per-channel ready.
- data_o  out  36  output line.
- src_rdy_o  out  1  output valid.
- dst_rdy_i  in  1  downstream ready.
- status  out  32  {CNT_W-bit pkt_count, 8'b0 padding to bit 16, 4'b0, busy, grant[2:0]}. Bits above CNT_W+16 read 0.

## Operation
- Control word is written when set_stb is high and set_addr == BASE:
  - en_mask = set_data[7:0]; bits at index NUM_CH and above are ignored.
  - hi_mask = set_data[15:8].
- Reset values: en_mask = all ones, hi_mask = 0.
- Eligible channel: src_rdy_i[k] & en_mask[k].
- State machine:
  - IDLE: if any eligible channel has hi_mask set, choose among the high-class channels; otherwise choose among all eligible channels. Within the chosen set, pick round-robin starting at (last_grant+1) mod NUM_CH. Register the winner into grant and go to DATA. If nothing is eligible, stay in IDLE.
  - DATA: data_o = data_i[grant]; src_rdy_o = src_rdy_i[grant]; dst_rdy_o[grant] = dst_rdy_i. All other dst_rdy_o bits are 0.
  - When the granted channel transfers a line with EOF set (src_rdy & dst_rdy & data[33]), increment pkt_count, set last_grant = grant, and return to IDLE.
- The grant is packet-atomic. Changes to en_mask or hi_mask during DATA take effect only at the next IDLE decision; the current packet always completes.
- A single-line packet (SOF and EOF on the same line) is legal and occupies one DATA cycle.
- The block does not check SOF. The first line after a grant is forwarded as-is.
- pkt_count wraps from all ones to 0 without saturating.
- Reset or clear: go to IDLE; grant = 0, last_grant = NUM_CH-1 so that channel 0 is searched first; pkt_count = 0. Control registers return to their reset values on reset only, not on clear.
- If clear is asserted mid-packet, the in-flight packet is truncated at the output. Upstream flushing is the caller's responsibility.

## Timing
- Output reset values: src_rdy_o = 0, dst_rdy_o = 0, data_o = data_i[0] (don't-care while invalid), status = 0.
- Datapath is combinational from the granted input to the output: zero latency, full throughput of one line per cycle during DATA.
- Each packet boundary costs exactly one IDLE cycle. Back-to-back packets are therefore sustained at one bubble per packet.
- Output handshake: while in DATA, data_o and src_rdy_o stay stable until dst_rdy_i is asserted. No combinational path exists from dst_rdy_i to src_rdy_o.
- busy = (state == DATA). Status fields are registered or direct from state registers.
- A control write in the same cycle as an IDLE decision takes effect on the following decision.

## Structure
- Shared package (fifo36_pkg):
  - constants FIFO36_SOF = 32, FIFO36_EOF = 33, FIFO36_OCC_HI = 35, FIFO36_OCC_LO = 34.
  - state encoding for IDLE and DATA.
- Sub-module rr_pick_n (NUM_CH): combinational round-robin priority encoder.
  - Inputs: request mask, last index.
  - Outputs: found, index.
  - Instantiated twice, once for the high-class set and once for the full eligible set.
- Top level contains the FSM, the setting register, the output mux and the counter.

## Test plan
- NUM_CH=4, channels 0..3 each hold three 4-line packets, masks at reset values -> output order is ch0, ch1, ch2, ch3, repeated. pkt_count reads 12. Exactly one invalid cycle appears between packets.
- Write hi_mask = 0x04 with all channels continuously valid -> channel 2 wins every arbitration. Clearing hi_mask restores rotation, starting at channel 3.
- Write en_mask = 0x0D while channel 1 is mid-packet -> channel 1's packet completes, then channel 1 receives no further grants.
- Random dst_rdy_i backpressure at 50% duty on a 100-line packet -> all 100 lines emerge in order, each held stable while dst_rdy_i is low, and no ungranted dst_rdy_o bit is ever high.
- Single-line packets (SOF=EOF=1) on channels 0 and 1 -> they alternate at one packet every 2 cycles.
- Assert reset on line 5 of a 10-line packet -> all outputs return to reset values immediately. After release, channel 0 is granted first and pkt_count = 0.
